// File: rtl/decode_system_pipe_pkg.sv
// Shared types and constants for the RV32 SYSTEM-opcode decode stage.
// Contents: system_kind_t (decoded kind), priv_t and PRIV_* levels,
// OPC_SYSTEM, F12_* funct12 encodings, sys_dec_t (registered decode payload).
package decode_system_pipe_pkg;

  typedef enum logic [3:0] {
    sysk_invalid,
    sysk_ecall,
    sysk_ebreak,
    sysk_mret,
    sysk_sret,
    sysk_wfi,
    sysk_csrrw,
    sysk_csrrs,
    sysk_csrrc,
    sysk_csrrwi,
    sysk_csrrsi,
    sysk_csrrci
  } system_kind_t;

  typedef logic [1:0] priv_t;

  localparam priv_t PRIV_U = 2'b00;
  localparam priv_t PRIV_S = 2'b01;
  localparam priv_t PRIV_M = 2'b11;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;
  localparam logic [11:0] F12_SRET   = 12'h102;
  localparam logic [11:0] F12_WFI    = 12'h105;

  typedef struct packed {
    system_kind_t kind;
    logic [11:0]  csr_addr;
    logic [4:0]   csr_src;
    logic         csr_src_imm;
    logic [4:0]   rd;
    logic         csr_rd_en;
    logic         csr_wr_en;
    logic         illegal;
  } sys_dec_t;

endpackage

// File: rtl/decode_system_pipe_skid.sv
// Two-entry valid/ready pipeline register with skid slot, generic payload.
// Ports: clk_i, rst_ni (async active-low), flush_i (sync, drops both entries),
// in_valid_i/in_ready_o/in_data_i upstream, out_valid_o/out_ready_i/out_data_o
// downstream. in_ready_o is registered: it is simply "skid slot empty".
module decode_system_pipe_skid #(
  parameter type T        = logic [7:0],
  parameter T    ResetVal = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic out_valid_q, skid_valid_q;
  T     out_q, skid_q;
  logic push, pop;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;
  assign push        = in_valid_i & ~skid_valid_q;
  assign pop         = out_valid_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= ResetVal;
      skid_q       <= ResetVal;
    end else if (flush_i) begin
      // Flush wins over any same-cycle accept; the payload regs keep stale data.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || pop) begin
      // Output slot free this cycle: skid has priority to keep ordering.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (push) begin
        out_q       <= in_data_i;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (push) begin
      // Output stalled: park the new word in the skid slot.
      skid_q       <= in_data_i;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/decode_system_pipe.sv
// Registered decoder for the RV32 SYSTEM opcode (ECALL/EBREAK, MRET/SRET/WFI,
// Zicsr) with CSR side-effect and privilege/read-only legality resolution.
// Ports: clk_i, rst_ni (async active-low), flush_i; in_valid_i/in_ready_o,
// instr_i[31:0], priv_i[1:0]; out_valid_o/out_ready_i; kind_o, csr_addr_o,
// csr_src_o, csr_src_imm_o, rd_o, csr_rd_en_o, csr_wr_en_o, illegal_o.
// Optional: DECODE_SYSTEM_PIPE_STATS_EN adds illegal_count_o[15:0], a
// saturating count of illegal results handed downstream (cleared by reset only).
module decode_system_pipe
  import decode_system_pipe_pkg::*;
#(
  parameter bit           SUPPORT_S  = 1'b1,
  parameter bit           SUPPORT_U  = 1'b1,
  parameter system_kind_t RESET_KIND = sysk_invalid
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  instr_i,
  input  logic [1:0]   priv_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output system_kind_t kind_o,
  output logic [11:0]  csr_addr_o,
  output logic [4:0]   csr_src_o,
  output logic         csr_src_imm_o,
  output logic [4:0]   rd_o,
  output logic         csr_rd_en_o,
  output logic         csr_wr_en_o,
`ifdef DECODE_SYSTEM_PIPE_STATS_EN
  output logic [15:0]  illegal_count_o,
`endif
  output logic         illegal_o
);

  localparam sys_dec_t ResetDec = '{kind: RESET_KIND, default: '0};

  function automatic sys_dec_t decode(logic [31:0] ins, priv_t priv);
    sys_dec_t d;
    priv_t    eff;
    logic [2:0] f3;
    d             = '0;
    d.kind        = sysk_invalid;
    d.illegal     = 1'b1;
    d.csr_addr    = ins[31:20];
    d.csr_src     = ins[19:15];
    d.rd          = ins[11:7];
    d.csr_src_imm = ins[14];
    f3            = ins[14:12];
    eff           = (!SUPPORT_U && priv == PRIV_U) ? PRIV_M : priv;
    if (ins[6:0] == OPC_SYSTEM) begin
      if (f3 == 3'b000) begin
        if (ins[11:7] == 5'd0 && ins[19:15] == 5'd0) begin
          case (ins[31:20])
            F12_ECALL:  begin d.kind = sysk_ecall;  d.illegal = 1'b0; end
            F12_EBREAK: begin d.kind = sysk_ebreak; d.illegal = 1'b0; end
            F12_MRET:   begin d.kind = sysk_mret;   d.illegal = (eff != PRIV_M); end
            F12_SRET: begin
              d.kind    = sysk_sret;
              d.illegal = !SUPPORT_S || (eff == PRIV_U);
            end
            F12_WFI:    begin d.kind = sysk_wfi;    d.illegal = 1'b0; end
            default:    ;
          endcase
        end
      end else if (f3 != 3'b100) begin
        case (f3)
          3'b001:  d.kind = sysk_csrrw;
          3'b010:  d.kind = sysk_csrrs;
          3'b011:  d.kind = sysk_csrrc;
          3'b101:  d.kind = sysk_csrrwi;
          3'b110:  d.kind = sysk_csrrsi;
          default: d.kind = sysk_csrrci;
        endcase
        if (f3[1:0] == 2'b01) begin
          d.csr_wr_en = 1'b1;
          d.csr_rd_en = (ins[11:7] != 5'd0);
        end else begin
          d.csr_rd_en = 1'b1;
          d.csr_wr_en = (ins[19:15] != 5'd0);
        end
        // addr[9:8] is the lowest privilege allowed; addr[11:10]==11 is read-only.
        d.illegal = (ins[29:28] > eff) ||
                    (ins[31:30] == 2'b11 && d.csr_wr_en) ||
                    (!SUPPORT_S && ins[29:28] == PRIV_S);
        if (d.illegal) begin
          d.csr_rd_en = 1'b0;
          d.csr_wr_en = 1'b0;
        end
      end
    end
    return d;
  endfunction

  sys_dec_t dec_in, dec_out;

  assign dec_in = decode(instr_i, priv_i);

  decode_system_pipe_skid #(
    .T        (sys_dec_t),
    .ResetVal (ResetDec)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (dec_in),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (dec_out)
  );

  assign kind_o        = dec_out.kind;
  assign csr_addr_o    = dec_out.csr_addr;
  assign csr_src_o     = dec_out.csr_src;
  assign csr_src_imm_o = dec_out.csr_src_imm;
  assign rd_o          = dec_out.rd;
  assign csr_rd_en_o   = dec_out.csr_rd_en;
  assign csr_wr_en_o   = dec_out.csr_wr_en;
  assign illegal_o     = dec_out.illegal;

`ifdef DECODE_SYSTEM_PIPE_STATS_EN
  logic [15:0] illegal_cnt_q, illegal_cnt_d;

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (out_valid_o && out_ready_i && dec_out.illegal && illegal_cnt_q != 16'hFFFF) begin
      illegal_cnt_d = illegal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) illegal_cnt_q <= 16'd0;
    else         illegal_cnt_q <= illegal_cnt_d;
  end

  assign illegal_count_o = illegal_cnt_q;
`endif

endmodule
